// File: rtl/bsg_cgol_run_ctrl.sv
// Run controller for the Game-of-Life cell array: accepts a job, issues one advance
// strobe per generation spaced by gen_latency_p, and reports the generations executed.
module bsg_cgol_run_ctrl #(
  parameter int max_game_length_p = 1024,
  parameter int gen_latency_p     = 1,
  localparam int game_len_width_lp = $clog2(max_game_length_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [game_len_width_lp-1:0] frames_i,
  input  logic [1:0]                   mode_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic                         abort_i,
  output logic                         v_o,
  input  logic                         yumi_i,
  output logic [game_len_width_lp-1:0] gen_count_o,
  output logic                         busy_o,
  output logic                         update_o,
  output logic                         en_o
);

  localparam int phase_width_lp = (gen_latency_p > 1) ? $clog2(gen_latency_p) : 1;
  localparam logic [phase_width_lp-1:0]    phase_last_lp = phase_width_lp'(gen_latency_p - 1);
  localparam logic [game_len_width_lp-1:0] max_len_lp    = game_len_width_lp'(max_game_length_p);
  localparam logic [1:0] mode_step_lp = 2'd1;
  localparam logic [1:0] mode_free_lp = 2'd2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                         state_q, state_d;
  logic                           free_q, free_d;
  logic [game_len_width_lp-1:0]   target_q, target_d;
  logic [game_len_width_lp-1:0]   gen_count_q, gen_count_d;
  logic [phase_width_lp-1:0]      phase_q, phase_d;
  logic                           abort_pending_q, abort_pending_d;
  logic                           accept;
  logic                           gen_due;
  logic                           more_due;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    free_d          = free_q;
    target_d        = target_q;
    gen_count_d     = gen_count_q;
    phase_d         = phase_q;
    abort_pending_d = abort_pending_q;
    accept          = 1'b0;
    gen_due         = 1'b0;
    more_due        = 1'b0;
    ready_o         = 1'b0;
    update_o        = 1'b0;
    busy_o          = 1'b0;
    en_o            = 1'b0;
    v_o             = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_o = ~reset_i;
        accept  = v_i & ~reset_i;
        if (accept) begin
          update_o        = 1'b1;
          gen_count_d     = '0;
          phase_d         = '0;
          abort_pending_d = 1'b0;
          free_d          = (mode_i == mode_free_lp);
          if (mode_i == mode_step_lp)      target_d = game_len_width_lp'(1);
          else if (free_d)                 target_d = '0;
          else if (frames_i > max_len_lp)  target_d = max_len_lp;
          else                             target_d = frames_i;
          state_d = (free_d || (target_d != '0)) ? BUSY : DONE;
        end
      end

      BUSY: begin
        busy_o  = 1'b1;
        gen_due = free_q || (gen_count_q < target_q);
        en_o    = (phase_q == '0) && gen_due && ~abort_i && ~abort_pending_q;
        if (en_o && (gen_count_q != '1))
          gen_count_d = gen_count_q + game_len_width_lp'(1);
        more_due = free_q || (gen_count_d < target_q);

        // An abort at phase 0 has nothing in flight; otherwise let the generation finish.
        if ((phase_q == '0) && abort_i)
          state_d = DONE;
        else if ((phase_q == phase_last_lp) && (!more_due || abort_pending_q || abort_i))
          state_d = DONE;
        else if (abort_i)
          abort_pending_d = 1'b1;

        phase_d = (phase_q == phase_last_lp) ? '0 : phase_q + phase_width_lp'(1);
        if (state_d == DONE) abort_pending_d = 1'b0;
      end

      DONE: begin
        v_o = 1'b1;
        if (yumi_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      free_q          <= 1'b0;
      target_q        <= '0;
      gen_count_q     <= '0;
      phase_q         <= '0;
      abort_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      free_q          <= free_d;
      target_q        <= target_d;
      gen_count_q     <= gen_count_d;
      phase_q         <= phase_d;
      abort_pending_q <= abort_pending_d;
    end
  end

  assign gen_count_o = gen_count_q;

endmodule

// File: doc/bsg_cgol_run_ctrl.md
Name: bsg_cgol_run_ctrl

Overview:
- Run controller for the Game-of-Life cell array; the multi-mode, multi-cycle-generation successor of the single-mode frame controller.
- Accepts a job (mode + frame count) over a valid/ready channel and pulses the array's load strobe.
- Issues one advance strobe per generation, spaced by a parametrised generation latency. Supports run-N, single-step and free-run modes with abort.
- Reports completion and the number of generations actually executed over a valid/yumi channel.

Parameters:
- max_game_length_p, 1024: largest frame count a job may request. The frame count and generation count width is game_len_width_lp = clog2(max_game_length_p+1).
- gen_latency_p, 1: cycles the cell array needs per generation (>=1). Successive en_o pulses are this many cycles apart.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- frames_i  in  game_len_width_lp  requested generation count (RUN_N mode).
- mode_i  in  2  0=RUN_N, 1=STEP, 2=FREE, 3=treated as RUN_N.
- v_i  in  1  job valid.
- ready_o  out  1  controller can accept a job.
- abort_i  in  1  stop the current job after the in-flight generation.
- v_o  out  1  job complete; gen_count_o valid.
- yumi_i  in  1  consumer takes the result.
- gen_count_o  out  game_len_width_lp  generations executed by the last job.
- busy_o  out  1  job in progress.
- update_o  out  1  load strobe to the cell array.
- en_o  out  1  advance-one-generation strobe to the cell array.

Behaviour:
- Reset (asynchronous, any time including mid-job):
  - State=IDLE; target, generation count, phase counter and abort_pending cleared.
  - All outputs 0 while reset_i is high, including ready_o (gated by ~reset_i).
  - ready_o=1 from the first cycle after deassertion.
- States: IDLE, BUSY, DONE.
- IDLE:
  - ready_o=1.
  - Accept when v_i&ready_o: update_o=1 that cycle (combinational); latch mode; clear gen_count.
  - Target latch per mode:
    - RUN_N: frames_i, clamped to max_game_length_p.
    - STEP: 1.
    - FREE: unbounded.
  - Next state is BUSY, or DONE directly if the target is 0.
  - v_i without ready_o is ignored.
- BUSY:
  - busy_o=1. A phase counter runs 0..gen_latency_p-1 and wraps.
  - en_o = (phase==0) & (gen_count<target, or FREE) & ~abort_i & ~abort_pending.
  - gen_count increments on each en_o. In FREE mode it saturates at all-ones and the job keeps running.
  - Exit to DONE on the cycle after phase gen_latency_p-1 completes with no further generation due.
  - Cycle timing for accept at cycle 0, target N>0, latency L:
    - en_o at cycles 1, 1+L, ..., 1+(N-1)L.
    - v_o first high at cycle 1+N*L.
- Abort (BUSY only):
  - abort_i at phase 0 suppresses that en_o; DONE next cycle.
  - abort_i at phase!=0 sets abort_pending; the in-flight generation finishes; DONE on phase wrap; no further en_o.
  - abort_i in IDLE or DONE is ignored. abort_pending clears on entering DONE.
- DONE:
  - v_o=1; gen_count_o holds the count, stable until yumi_i.
  - v_o&yumi_i moves to IDLE next cycle. yumi_i without v_o is ignored.
  - A new job cannot be accepted in the same cycle as yumi_i.
- Simultaneous events:
  - Final en_o and abort_i in the same cycle: the abort wins and en_o stays 0.
  - gen_count_o then reports generations actually issued.
- update_o and en_o are never high in the same cycle.

Test Plan:
- L=1, mode RUN_N, frames_i=3 accepted at cycle 0 -> update_o at cycle 0; en_o at cycles 1,2,3; v_o at cycle 4; gen_count_o=3; yumi at cycle 6 -> ready_o at cycle 7.
- L=3, mode STEP, frames_i=50 -> exactly one en_o at cycle 1; v_o at cycle 4; gen_count_o=1.
- RUN_N with frames_i=0 -> update_o pulse, no en_o, v_o at cycle 1, gen_count_o=0. frames_i=max+5 (if representable) -> clamped, gen_count_o=max_game_length_p.
- L=2, FREE, abort_i at cycle 6 (phase 1) -> en_o at cycles 1,3,5 only; v_o at cycle 7; gen_count_o=3. Repeat with abort at cycle 5 (phase 0) -> en_o at cycles 1,3 only; v_o at cycle 6; gen_count_o=2.
- reset_i asserted asynchronously mid-BUSY (between clock edges) -> en_o, busy_o and ready_o drop immediately. After deassertion: ready_o=1, v_o=0, gen_count_o=0, and a new job runs normally.
- v_i held high through BUSY/DONE, and yumi_i pulsed in IDLE/BUSY -> no extra update_o, no state change; only one job runs per IDLE acceptance.
